// File: rtl/pwm_counter_pkg.sv
// Shared constants and types for the PWM timebase counter.
package pwm_pkg;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned PSC_W = 8;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_counter_if.sv
// Register-block <-> timebase counter connection: control fields in, count and wrap pulse out.
interface pwm_counter_if;
    import pwm_pkg::*;

    logic             en;
    logic             count_reset;
    logic             upnotdown;
    logic [CNT_W-1:0] period;
    logic [PSC_W-1:0] prescale;
    logic [CNT_W-1:0] counter_val;
    logic             ovf;

    modport master (
        output en, count_reset, upnotdown, period, prescale,
        input  counter_val, ovf
    );

    modport slave (
        input  en, count_reset, upnotdown, period, prescale,
        output counter_val, ovf
    );
endinterface

// File: rtl/pwm_counter_prescaler.sv
// Prescaler: counts enabled cycles 0..prescale and flags the cycle that advances the counter.
module pwm_prescaler
    import pwm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [PSC_W-1:0] prescale_i,
    output logic             tick_c_o
);

    logic [PSC_W-1:0] psc_cnt_q;
    logic [PSC_W-1:0] psc_cnt_d;
    logic             at_term_c;

    assign at_term_c = (psc_cnt_q == prescale_i);
    // Clear wins over enable, so no tick can escape during a counter clear.
    assign tick_c_o  = en_i && !clr_i && at_term_c;

    always_comb begin
        psc_cnt_d = psc_cnt_q;
        if (clr_i) begin
            psc_cnt_d = '0;
        end else if (en_i) begin
            psc_cnt_d = at_term_c ? '0 : psc_cnt_q + PSC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_cnt_q <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
        end
    end

endmodule

// File: rtl/pwm_counter.sv
// PWM timebase: up/down counter between 0 and period with prescaled advance and a wrap pulse.
// Define PWM_COUNTER_SHADOW_EN to latch period/prescale/direction only at wraps and count_reset.
module pwm_counter
    import pwm_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    pwm_counter_if.slave  bus
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             wrap_c;
    logic             tick_c;
    logic [CNT_W-1:0] period_a;
    logic [PSC_W-1:0] prescale_a;
    dir_e             dir_a;
    dir_e             dir_live;

    assign dir_live = dir_e'(bus.upnotdown);

`ifdef PWM_COUNTER_SHADOW_EN
    logic [CNT_W-1:0] period_sh_q;
    logic [PSC_W-1:0] prescale_sh_q;
    dir_e             dir_sh_q;

    // Settings take effect only at a period boundary or on an explicit clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_sh_q   <= '0;
            prescale_sh_q <= '0;
            dir_sh_q      <= DIR_UP;
        end else if (bus.count_reset || wrap_c) begin
            period_sh_q   <= bus.period;
            prescale_sh_q <= bus.prescale;
            dir_sh_q      <= dir_live;
        end
    end

    assign period_a   = period_sh_q;
    assign prescale_a = prescale_sh_q;
    assign dir_a      = dir_sh_q;
`else
    assign period_a   = bus.period;
    assign prescale_a = bus.prescale;
    assign dir_a      = dir_live;
`endif

    pwm_prescaler u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .en_i       (bus.en),
        .clr_i      (bus.count_reset),
        .prescale_i (prescale_a),
        .tick_c_o   (tick_c)
    );

    // Up mode uses >= so a period lowered below the count still wraps cleanly.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_c = 1'b0;
        if (bus.count_reset) begin
            cnt_d = (dir_live == DIR_UP) ? '0 : bus.period;
        end else if (tick_c) begin
            if (dir_a == DIR_UP) begin
                if (cnt_q >= period_a) begin
                    cnt_d  = '0;
                    wrap_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d  = period_a;
                    wrap_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end
        ovf_d = wrap_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.counter_val = cnt_q;
    assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_pwm_counter.sv
// Scoreboard bench for pwm_counter: driver queues hand-computed results, monitor checks each edge.
module tb_pwm_counter;
    import pwm_pkg::*;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic             ovf;
        string            tag;
    } exp_t;

    logic  clk;
    logic  rst;
    exp_t  exp_q[$];
    string cur_tag;
    int    n_tests;
    int    n_fail;

    pwm_counter_if bus_if ();

    pwm_counter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Called at a falling edge with inputs already set; result is due after the next rising edge.
    task automatic ex(input int c, input int o);
        exp_t e;
        e.cnt = CNT_W'(c);
        e.ovf = 1'(o);
        e.tag = cur_tag;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drive(input logic e, input logic cr, input logic up,
                         input int per, input int psc);
        bus_if.en          = e;
        bus_if.count_reset = cr;
        bus_if.upnotdown   = up;
        bus_if.period      = CNT_W'(per);
        bus_if.prescale    = PSC_W'(psc);
    endtask

    // Monitor: compare every rising edge for which an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, ".cnt"}, bus_if.counter_val, e.cnt);
                chk({e.tag, ".ovf"}, CNT_W'(bus_if.ovf), CNT_W'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 0, 0);
        #12;
        chk("reset.cnt", bus_if.counter_val, CNT_W'(0));
        chk("reset.ovf", CNT_W'(bus_if.ovf), CNT_W'(0));
        @(negedge clk);
        rst = 1'b0;

        cur_tag = "up";
        drive(1'b1, 1'b1, 1'b1, 3, 0); ex(0, 0);
        drive(1'b1, 1'b0, 1'b1, 3, 0);
        ex(1, 0); ex(2, 0); ex(3, 0); ex(0, 1); ex(1, 0); ex(2, 0); ex(3, 0); ex(0, 1); ex(1, 0);

        cur_tag = "down";
        drive(1'b1, 1'b1, 1'b0, 3, 0); ex(3, 0);
        drive(1'b1, 1'b0, 1'b0, 3, 0);
        ex(2, 0); ex(1, 0); ex(0, 0); ex(3, 1); ex(2, 0); ex(1, 0); ex(0, 0); ex(3, 1);

        cur_tag = "psc";
        drive(1'b1, 1'b1, 1'b1, 5, 2); ex(0, 0);
        drive(1'b1, 1'b0, 1'b1, 5, 2);
        ex(0, 0); ex(0, 0); ex(1, 0); ex(1, 0); ex(1, 0); ex(2, 0); ex(2, 0);
        cur_tag = "psc_hold";
        drive(1'b0, 1'b0, 1'b1, 5, 2);
        ex(2, 0); ex(2, 0); ex(2, 0); ex(2, 0);
        cur_tag = "psc_resume";
        drive(1'b1, 1'b0, 1'b1, 5, 2);
        ex(2, 0); ex(3, 0); ex(3, 0); ex(3, 0); ex(4, 0); ex(4, 0); ex(4, 0);
        ex(5, 0); ex(5, 0); ex(5, 0); ex(0, 1); ex(0, 0); ex(0, 0); ex(1, 0);

        cur_tag = "clr";
        drive(1'b1, 1'b1, 1'b1, 10, 0); ex(0, 0);
        drive(1'b1, 1'b0, 1'b1, 10, 0);
        for (int i = 1; i <= 7; i++) ex(i, 0);
        drive(1'b1, 1'b1, 1'b1, 10, 0); ex(0, 0); ex(0, 0);
        drive(1'b1, 1'b0, 1'b1, 10, 0); ex(1, 0); ex(2, 0);

        cur_tag = "per_chg";
        drive(1'b1, 1'b1, 1'b1, 10, 0); ex(0, 0);
        drive(1'b1, 1'b0, 1'b1, 10, 0);
        for (int i = 1; i <= 6; i++) ex(i, 0);
        drive(1'b1, 1'b0, 1'b1, 4, 0);
`ifdef PWM_COUNTER_SHADOW_EN
        ex(7, 0); ex(8, 0); ex(9, 0); ex(10, 0); ex(0, 1);
`else
        ex(0, 1);
`endif
        ex(1, 0); ex(2, 0); ex(3, 0); ex(4, 0); ex(0, 1);

        cur_tag = "dir_chg";
        drive(1'b1, 1'b1, 1'b1, 3, 0); ex(0, 0);
        drive(1'b1, 1'b0, 1'b1, 3, 0); ex(1, 0); ex(2, 0);
        drive(1'b1, 1'b0, 1'b0, 3, 0);
`ifdef PWM_COUNTER_SHADOW_EN
        ex(3, 0); ex(0, 1); ex(3, 1); ex(2, 0);
`else
        ex(1, 0); ex(0, 0); ex(3, 1); ex(2, 0);
`endif

        cur_tag = "per0_up";
        drive(1'b1, 1'b1, 1'b1, 0, 0); ex(0, 0);
        drive(1'b1, 1'b0, 1'b1, 0, 0); ex(0, 1); ex(0, 1); ex(0, 1);
        cur_tag = "per0_dn";
        drive(1'b1, 1'b1, 1'b0, 0, 0); ex(0, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 0); ex(0, 1); ex(0, 1);

        cur_tag = "arst";
        drive(1'b1, 1'b1, 1'b1, 10, 0); ex(0, 0);
        drive(1'b1, 1'b0, 1'b1, 10, 0); ex(1, 0); ex(2, 0); ex(3, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst.cnt_async", bus_if.counter_val, CNT_W'(0));
        chk("arst.ovf_async", CNT_W'(bus_if.ovf), CNT_W'(0));
        @(negedge clk);
        rst = 1'b0;
`ifdef PWM_COUNTER_SHADOW_EN
        ex(0, 1); ex(1, 0); ex(2, 0);
`else
        ex(1, 0); ex(2, 0); ex(3, 0);
`endif

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
